store_buffer: RTL and testbench
===============================

# store_buffer

Queues committed stores from the MEM stage and drains them into `datamemory` on cycles no load needs the port, so stores do not stall the pipeline while loads are serviced. Sits directly upstream of `datamemory` and drives its `MemRead`, `MemWrite`, `a`, `wd` and `Funct3` inputs. Loads that overlap a buffered store are held until that store has drained, so memory ordering is preserved.

## Interface
- `DM_ADDRESS`, 9, byte-address width; matches `datamemory`.
- `DATA_W`, 32, data width.
- `DEPTH`, 4, number of buffer entries; power of two, ≥2.

- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `st_valid`  in  1  store request from MEM stage.
- `st_addr`  in  DM_ADDRESS  store byte address.
- `st_data`  in  DATA_W  store data, unshifted.
- `st_funct3`  in  3  store width: 000 SB, 001 SH, others SW.
- `st_ready`  out  1  buffer can accept a store this cycle.
- `ld_valid`  in  1  load request from MEM stage.
- `ld_addr`  in  DM_ADDRESS  load byte address.
- `ld_funct3`  in  3  load type, passed through to `datamemory`.
- `ld_stall`  out  1  load not issued this cycle; hold the MEM stage.
- `ld_fwd_valid`  out  1  load satisfied from buffer (forwarding build only; 0 otherwise).
- `ld_fwd_data`  out  DATA_W  forwarded word (0 when `ld_fwd_valid`=0).
- `MemRead`  out  1  to `datamemory`.
- `MemWrite`  out  1  to `datamemory`.
- `a`  out  DM_ADDRESS  to `datamemory`.
- `wd`  out  DATA_W  to `datamemory`.
- `Funct3`  out  3  to `datamemory`.
- `empty`  out  1  no buffered stores.

## Operation
- Circular FIFO: `head`, `tail` pointers of width log2(DEPTH), wrapping modulo DEPTH. `count` has range 0..DEPTH. Each entry holds {addr, data, funct3}.
- `st_ready` = (`count` < DEPTH). It does not account for a drain in the same cycle.
- Enqueue when `st_valid && st_ready`. A store with `st_valid` while full is not accepted; the MEM stage must hold it.
- Conflict: some valid entry has entry.addr[DM_ADDRESS-1:2] == ld_addr[DM_ADDRESS-1:2]. The comparison is on word address, regardless of width.
- Port arbitration, evaluated combinationally each cycle, in priority order:
  1. `count`==DEPTH: drain head; if `ld_valid`, `ld_stall`=1.
  2. `ld_valid` with conflict and no forward: drain head, `ld_stall`=1.
  3. `ld_valid`, no conflict: issue load with `MemRead`=1, `a`=`ld_addr`, `Funct3`=`ld_funct3`, `ld_stall`=0.
  4. No load, `count`>0: drain head.
  5. Otherwise idle: `MemRead`=`MemWrite`=0.
- Drain: `MemWrite`=1, `a`/`wd`/`Funct3` = head entry. Head and count advance at the next rising edge.
- The store in the load's own cycle is not yet buffered, so it is not compared against that load.
- Simultaneous enqueue and drain: `count` is unchanged and both pointers advance.
- When idle, `a`, `wd` and `Funct3` are 0.

## Timing
- `datamemory` captures writes on the falling edge of `clk`. All outputs are combinational from registered state and current inputs, and must be stable before the falling edge.
- Store acceptance: the entry is visible in conflict compare and `count` from the first rising edge after acceptance. The earliest drain is the following cycle.
- Load: zero added latency when no conflict. Each conflicting entry costs at least one stall cycle; older entries ahead of it drain first.
- Reset, synchronous: `head`=`tail`=0, `count`=0. Entries are cleared and all pending stores are discarded, including mid-drain.
- Output values in reset/empty with no load: `st_ready`=1, `empty`=1, `ld_stall`=0, `ld_fwd_valid`=0, `ld_fwd_data`=0, `MemRead`=0, `MemWrite`=0, `a`=0, `wd`=0, `Funct3`=0.

## Configuration
- `STORE_BUF_FWD_EN` defined: store-to-load forwarding is enabled. Forwarding applies only when all of the following hold:
  - `ld_funct3`==010 (LW);
  - the youngest conflicting entry has funct3 SW and exactly equal addr.
  
  In that case: `ld_fwd_valid`=1, `ld_fwd_data`=that entry's data, `ld_stall`=0, and `MemRead`=0. The port is used for a drain if `count`>0. Rule 1 still takes precedence. Any other conflict stalls per rule 2.
- Not defined: `ld_fwd_valid` and `ld_fwd_data` are tied 0, and every conflict stalls.

## Test plan
- Reset, then idle → all outputs at reset values; `st_ready`=1, `empty`=1.
- Store SW addr 0x010 data 0xDEADBEEF, no loads → next cycle `MemWrite`=1, `a`=0x010, `wd`=0xDEADBEEF, `Funct3`=010; the cycle after, `empty`=1.
- 4 stores back-to-back (addr 0x000, 0x004, 0x008, 0x00C) under continuous non-conflicting loads (addr 0x100) → `st_ready`=0 once full. Next cycle: `ld_stall`=1 and addr 0x000 drains. Loads resume after that.
- Buffered SB addr 0x021 data 0xAB, then LB addr 0x023 → `ld_stall`=1 until that entry drains. The load issues the next cycle with `a`=0x023 and `MemRead`=1.
- `STORE_BUF_FWD_EN`: buffered SW addr 0x040 data 0x12345678, then LW addr 0x040 → same cycle `ld_fwd_valid`=1, `ld_fwd_data`=0x12345678, `ld_stall`=0. LH addr 0x040 instead → `ld_stall`=1.
- `reset` asserted with 3 entries buffered and a drain in flight → next cycle `count`=0, `empty`=1, `MemWrite`=0. Nothing further is written.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and datamemory: queues stores, drains them on free port cycles.
// Optional store-to-load forwarding is compiled in when STORE_BUF_FWD_EN is defined.
module store_buffer #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  st_valid,
   input  logic [DM_ADDRESS-1:0] st_addr,
   input  logic [DATA_W-1:0]     st_data,
   input  logic [2:0]            st_funct3,
   output logic                  st_ready,
   input  logic                  ld_valid,
   input  logic [DM_ADDRESS-1:0] ld_addr,
   input  logic [2:0]            ld_funct3,
   output logic                  ld_stall,
   output logic                  ld_fwd_valid,
   output logic [DATA_W-1:0]     ld_fwd_data,
   output logic                  MemRead,
   output logic                  MemWrite,
   output logic [DM_ADDRESS-1:0] a,
   output logic [DATA_W-1:0]     wd,
   output logic [2:0]            Funct3,
   output logic                  empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DM_ADDRESS-1:0] addr_q [DEPTH];
   logic [DM_ADDRESS-1:0] addr_d [DEPTH];
   logic [DATA_W-1:0]     data_q [DEPTH];
   logic [DATA_W-1:0]     data_d [DEPTH];
   logic [2:0]            f3_q   [DEPTH];
   logic [2:0]            f3_d   [DEPTH];
   logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]         count_q, count_d;

   logic          full;
   logic          push;
   logic          drain;
   logic          conflict;
   logic          fwd_hit;
   logic [PW-1:0] young_idx;
   logic [PW-1:0] scan_idx;

   assign full     = (count_q == CW'(DEPTH));
   assign st_ready = !full;
   assign empty    = (count_q == '0);
   assign push     = st_valid && st_ready;

   // Scan oldest to youngest so the last match is the youngest conflicting entry.
   always_comb begin
      conflict  = 1'b0;
      young_idx = '0;
      scan_idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         scan_idx = head_q + PW'(k);
         if ((CW'(k) < count_q) &&
             (addr_q[scan_idx][DM_ADDRESS-1:2] == ld_addr[DM_ADDRESS-1:2])) begin
            conflict  = 1'b1;
            young_idx = scan_idx;
         end
      end
   end

`ifdef STORE_BUF_FWD_EN
   assign fwd_hit = ld_valid && conflict && !full && (ld_funct3 == 3'b010) &&
                    (f3_q[young_idx] != 3'b000) && (f3_q[young_idx] != 3'b001) &&
                    (addr_q[young_idx] == ld_addr);
`else
   assign fwd_hit = 1'b0;
`endif

   assign ld_fwd_valid = fwd_hit;
   assign ld_fwd_data  = fwd_hit ? data_q[young_idx] : '0;

   // Port arbitration: a full buffer always drains, then loads, then idle drains.
   always_comb begin
      drain    = 1'b0;
      ld_stall = 1'b0;
      MemRead  = 1'b0;
      a        = '0;
      wd       = '0;
      Funct3   = '0;
      if (full) begin
         drain    = 1'b1;
         ld_stall = ld_valid;
      end else if (ld_valid && conflict && !fwd_hit) begin
         drain    = 1'b1;
         ld_stall = 1'b1;
      end else if (ld_valid && !conflict) begin
         MemRead = 1'b1;
         a       = ld_addr;
         Funct3  = ld_funct3;
      end else if (count_q != '0) begin
         drain = 1'b1;
      end
      if (drain) begin
         a      = addr_q[head_q];
         wd     = data_q[head_q];
         Funct3 = f3_q[head_q];
      end
   end

   assign MemWrite = drain;

   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      f3_d    = f3_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CW'(push) - CW'(drain);
      if (push) begin
         addr_d[tail_q] = st_addr;
         data_d[tail_q] = st_data;
         f3_d[tail_q]   = st_funct3;
         tail_d         = tail_q + 1'b1;
      end
      if (drain) begin
         head_d = head_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            f3_q[i]   <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= addr_d[i];
            data_q[i] <= data_d[i];
            f3_q[i]   <= f3_d[i];
         end
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_store_buffer;
  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [2:0]    f3;
  } ent_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          st_valid, st_ready, ld_valid, ld_stall, ld_fwd_valid;
  logic [AW-1:0] st_addr, ld_addr, a;
  logic [DW-1:0] st_data, ld_fwd_data, wd;
  logic [2:0]    st_funct3, ld_funct3, Funct3;
  logic          MemRead, MemWrite, empty;

  store_buffer #(.DM_ADDRESS(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
    .ld_stall(ld_stall), .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3),
    .empty(empty)
  );

  int checks   = 0;
  int failures = 0;

  // scoreboard: buffered stores, oldest first
  ent_t mq[$];
  logic e_drain, e_push, e_rst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver
  task automatic drive(input logic rst, input logic sv, input logic [AW-1:0] sa,
                       input logic [DW-1:0] sd, input logic [2:0] sf, input logic lv,
                       input logic [AW-1:0] la, input logic [2:0] lf);
    reset = rst; st_valid = sv; st_addr = sa; st_data = sd; st_funct3 = sf;
    ld_valid = lv; ld_addr = la; ld_funct3 = lf;
  endtask

  task automatic model_check();
    int n, yi;
    logic full, conf, fwd;
    logic e_mr, e_mw, e_stall, e_fv;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_wd, e_fd;
    logic [2:0] e_f3;
    n = mq.size();
    full = (n == DEPTH);
    conf = 1'b0; yi = -1;
    for (int i = 0; i < n; i++)
      if (mq[i].addr[AW-1:2] == ld_addr[AW-1:2]) begin conf = 1'b1; yi = i; end
    fwd = 1'b0;
`ifdef STORE_BUF_FWD_EN
    if (ld_valid && conf && !full && ld_funct3 == 3'b010)
      fwd = (mq[yi].f3 != 3'b000) && (mq[yi].f3 != 3'b001) && (mq[yi].addr == ld_addr);
`endif
    e_mr = 0; e_mw = 0; e_stall = 0; e_fv = fwd; e_a = '0; e_wd = '0; e_f3 = '0;
    e_fd = fwd ? mq[yi].data : '0;
    if (full) begin e_mw = 1; e_stall = ld_valid; end
    else if (ld_valid && conf && !fwd) begin e_mw = 1; e_stall = 1; end
    else if (ld_valid && !conf) begin e_mr = 1; e_a = ld_addr; e_f3 = ld_funct3; end
    else if (n > 0) e_mw = 1;
    if (e_mw) begin e_a = mq[0].addr; e_wd = mq[0].data; e_f3 = mq[0].f3; end
    check("st_ready", st_ready, n < DEPTH);
    check("empty", empty, n == 0);
    check("ld_stall", ld_stall, e_stall);
    check("ld_fwd_valid", ld_fwd_valid, e_fv);
    check("ld_fwd_data", ld_fwd_data, e_fd);
    check("MemRead", MemRead, e_mr);
    check("MemWrite", MemWrite, e_mw);
    check("a", a, e_a);
    check("wd", wd, e_wd);
    check("Funct3", Funct3, e_f3);
    e_drain = e_mw;
    e_push  = st_valid && (n < DEPTH);
    e_rst   = reset;
  endtask

  task automatic commit();
    @(posedge clk);
    if (e_rst) mq.delete();
    else begin
      if (e_drain) void'(mq.pop_front());
      if (e_push) mq.push_back('{addr: st_addr, data: st_data, f3: st_funct3});
    end
    #1;
  endtask

  task automatic step(input logic rst, input logic sv, input logic [AW-1:0] sa,
                      input logic [DW-1:0] sd, input logic [2:0] sf, input logic lv,
                      input logic [AW-1:0] la, input logic [2:0] lf);
    drive(rst, sv, sa, sd, sf, lv, la, lf);
    @(negedge clk);
    model_check();
    commit();
  endtask

  task automatic idle();
    step(0, 0, '0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    logic [AW-1:0] ra, rl;
    logic [2:0]    rlf;
    drive(1, 0, '0, '0, '0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    mq.delete();

    // reset state
    drive(0, 0, '0, '0, '0, 0, '0, '0);
    @(negedge clk);
    model_check();
    check("rst_st_ready", st_ready, 1);
    check("rst_empty", empty, 1);
    check("rst_MemWrite", MemWrite, 0);
    commit();

    // single SW drains next cycle
    step(0, 1, 9'h010, 32'hDEADBEEF, 3'b010, 0, '0, '0);
    drive(0, 0, '0, '0, '0, 0, '0, '0);
    @(negedge clk);
    model_check();
    check("sw_MemWrite", MemWrite, 1);
    check("sw_a", a, 9'h010);
    check("sw_wd", wd, 32'hDEADBEEF);
    check("sw_Funct3", Funct3, 3'b010);
    commit();
    drive(0, 0, '0, '0, '0, 0, '0, '0);
    @(negedge clk);
    model_check();
    check("sw_empty_after", empty, 1);
    commit();

    // fill under continuous non-conflicting loads
    for (int i = 0; i < 4; i++)
      step(0, 1, AW'(4 * i), DW'($urandom), 3'b010, 1, 9'h100, 3'b010);
    drive(0, 0, '0, '0, '0, 1, 9'h100, 3'b010);
    @(negedge clk);
    model_check();
    check("full_st_ready", st_ready, 0);
    check("full_ld_stall", ld_stall, 1);
    check("full_drain_a", a, 9'h000);
    commit();
    drive(0, 0, '0, '0, '0, 1, 9'h100, 3'b010);
    @(negedge clk);
    model_check();
    check("resume_MemRead", MemRead, 1);
    check("resume_ld_stall", ld_stall, 0);
    commit();
    repeat (4) idle();

    // LB conflicting with buffered SB (same word) stalls until drained
    step(0, 1, 9'h021, 32'h000000AB, 3'b000, 0, '0, '0);
    drive(0, 0, '0, '0, '0, 1, 9'h023, 3'b000);
    @(negedge clk);
    model_check();
    check("lb_stall", ld_stall, 1);
    check("lb_drain", MemWrite, 1);
    commit();
    @(negedge clk);
    model_check();
    check("lb_issue_stall", ld_stall, 0);
    check("lb_issue_MemRead", MemRead, 1);
    check("lb_issue_a", a, 9'h023);
    commit();

    // LW after SW to the same address
    step(0, 1, 9'h040, 32'h12345678, 3'b010, 0, '0, '0);
    drive(0, 0, '0, '0, '0, 1, 9'h040, 3'b010);
    @(negedge clk);
    model_check();
`ifdef STORE_BUF_FWD_EN
    check("lw_fwd_valid", ld_fwd_valid, 1);
    check("lw_fwd_data", ld_fwd_data, 32'h12345678);
    check("lw_fwd_stall", ld_stall, 0);
`else
    check("lw_nofwd_stall", ld_stall, 1);
    check("lw_nofwd_valid", ld_fwd_valid, 0);
`endif
    commit();
    idle();
    step(0, 1, 9'h040, 32'h12345678, 3'b010, 0, '0, '0);
    drive(0, 0, '0, '0, '0, 1, 9'h040, 3'b001);
    @(negedge clk);
    model_check();
    check("lh_stall", ld_stall, 1);
    commit();
    repeat (2) idle();

    // reset with three entries buffered and a drain in flight
    for (int i = 0; i < 3; i++)
      step(0, 1, AW'(8 + 4 * i), DW'($urandom), 3'b010, 1, 9'h100, 3'b010);
    drive(1, 0, '0, '0, '0, 0, '0, '0);
    @(negedge clk);
    model_check();
    check("rst_inflight_MemWrite", MemWrite, 1);
    commit();
    drive(0, 0, '0, '0, '0, 0, '0, '0);
    @(negedge clk);
    model_check();
    check("post_rst_empty", empty, 1);
    check("post_rst_MemWrite", MemWrite, 0);
    check("post_rst_st_ready", st_ready, 1);
    commit();
    repeat (2) idle();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      ra  = AW'($urandom_range(0, 31));
      rl  = ($urandom_range(0, 3) == 0) ? (9'h100 | AW'($urandom_range(0, 31)))
                                       : AW'($urandom_range(0, 31));
      rlf = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'($urandom_range(0, 7));
      step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), ra, DW'($urandom),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rl, rlf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
